// File: rtl/zx_cart_pkg.sv
// Shared types and constants for the ZX Spectrum cartridge page mapper.
package zx_cart_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int MODE_INC  = 0;
  localparam int MODE_LOAD = 1;

endpackage

// File: rtl/zx_sync_edge.sv
// Two-flop synchroniser with a one-cycle falling-edge pulse; all flops idle high.
// Edges are only accepted once a high level has been sampled after reset.
module zx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  logic s1, s2, s3;
  logic started, armed;

  // armed blocks a "fall" caused purely by the reset value being replaced
  // by a line that was already low when reset was released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s1      <= din;
      s2      <= s1;
      s3      <= s2;
      started <= 1'b1;
      if (started && s1) armed <= 1'b1;
    end
  end

  assign fall = armed & s3 & ~s2;

endmodule

// File: rtl/zx_cart_mapper.sv
// Cartridge ROM mapper: combinational window decode plus a page register
// advanced or loaded by Z80 port accesses, with optional one-way self-lock.
module zx_cart_mapper
  import zx_cart_pkg::*;
#(
  parameter int PAGE_W        = 6,
  parameter int SELF_LOCK_VAL = 63,
  parameter int LOCK_EN       = 1,
  parameter int MODE          = 0,
  parameter int WIN_KB        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              mreq_n,
  input  logic              A7,
  input  logic              A13,
  input  logic              A14,
  input  logic              A15,
  input  logic [7:0]        D,
  output logic              ZX_ROM_blk,
  output logic              CR_ROM_oe_n,
  output logic [PAGE_W-1:0] CR_ROM_A,
  output logic              locked
);

  state_t            state, state_nxt;
  logic [PAGE_W-1:0] page, page_nxt, new_page;
  logic              iorq_fall, port_evt, upd_en, lock_req, lower_rom;
  logic              a7_d1, a7_d2, wr_d1, wr_d2;
  logic [7:0]        d_d1, d_d2;
  logic              unused_d;

  zx_sync_edge u_iorq_sync (
    .clk   (clk),
    .reset (reset),
    .din   (iorq_n),
    .fall  (iorq_fall)
  );

  // Qualifiers ride alongside the iorq_n synchroniser so they line up with its output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a7_d1 <= 1'b0;
      a7_d2 <= 1'b0;
      wr_d1 <= 1'b1;
      wr_d2 <= 1'b1;
      d_d1  <= '0;
      d_d2  <= '0;
    end else begin
      a7_d1 <= A7;
      a7_d2 <= a7_d1;
      wr_d1 <= wr_n;
      wr_d2 <= wr_d1;
      d_d1  <= D;
      d_d2  <= d_d1;
    end
  end

  assign unused_d = ^d_d2;
  assign port_evt = iorq_fall & ~a7_d2;
  assign upd_en   = (MODE == MODE_INC) ? 1'b1 : ~wr_d2;
  assign new_page = (MODE == MODE_INC) ? page + PAGE_W'(1) : d_d2[PAGE_W-1:0];
  assign lock_req = (MODE == MODE_LOAD) && d_d2[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACTIVE;
      page  <= '0;
    end else begin
      state <= state_nxt;
      page  <= page_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    if (state == ACTIVE && port_evt && upd_en) begin
      page_nxt = new_page;
      if ((LOCK_EN != 0 && new_page == PAGE_W'(SELF_LOCK_VAL)) || lock_req)
        state_nxt = LOCKED;
    end
  end

  assign lower_rom   = (WIN_KB == 16) ? (~A15 & ~A14) : (~A15 & ~A14 & ~A13);
  assign locked      = (state == LOCKED);
  assign CR_ROM_A    = page;
  assign ZX_ROM_blk  = lower_rom & ~mreq_n & ~locked;
  assign CR_ROM_oe_n = ~(lower_rom & ~rd_n & ~mreq_n & ~locked);

endmodule

// File: tb/tb_zx_cart_mapper.sv
// Scoreboard bench for zx_cart_mapper: four parameterisations share one Z80 bus.
module tb_zx_cart_mapper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, mreq_n = 1'b1;
  logic       A7 = 1'b1, A13 = 1'b1, A14 = 1'b1, A15 = 1'b1;
  logic [7:0] D = 8'h00;

  logic [3:0] blk, oe, lk;
  logic [5:0] pg0, pg1, pg2;
  logic [1:0] pg3;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zx_cart_mapper #(.PAGE_W(6), .SELF_LOCK_VAL(3), .LOCK_EN(1), .MODE(0), .WIN_KB(8)) u0 (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n),
    .A7(A7), .A13(A13), .A14(A14), .A15(A15), .D(D),
    .ZX_ROM_blk(blk[0]), .CR_ROM_oe_n(oe[0]), .CR_ROM_A(pg0), .locked(lk[0]));

  zx_cart_mapper #(.PAGE_W(6), .SELF_LOCK_VAL(3), .LOCK_EN(1), .MODE(0), .WIN_KB(16)) u1 (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n),
    .A7(A7), .A13(A13), .A14(A14), .A15(A15), .D(D),
    .ZX_ROM_blk(blk[1]), .CR_ROM_oe_n(oe[1]), .CR_ROM_A(pg1), .locked(lk[1]));

  zx_cart_mapper #(.PAGE_W(6), .SELF_LOCK_VAL(63), .LOCK_EN(1), .MODE(1), .WIN_KB(8)) u2 (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n),
    .A7(A7), .A13(A13), .A14(A14), .A15(A15), .D(D),
    .ZX_ROM_blk(blk[2]), .CR_ROM_oe_n(oe[2]), .CR_ROM_A(pg2), .locked(lk[2]));

  zx_cart_mapper #(.PAGE_W(2), .SELF_LOCK_VAL(3), .LOCK_EN(0), .MODE(0), .WIN_KB(8)) u3 (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n),
    .A7(A7), .A13(A13), .A14(A14), .A15(A15), .D(D),
    .ZX_ROM_blk(blk[3]), .CR_ROM_oe_n(oe[3]), .CR_ROM_A(pg3), .locked(lk[3]));

  typedef struct {
    int         due;
    int         id;
    string      name;
    logic [5:0] page;
    logic       lk;
    bit         bus;
    logic       oe;
    logic       blk;
  } exp_t;

  exp_t q[$];

  function automatic logic [5:0] pg_of(int id);
    case (id)
      0:       return pg0;
      1:       return pg1;
      2:       return pg2;
      default: return {4'b0000, pg3};
    endcase
  endfunction

  // Monitor: pops every expectation whose sample cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] gp;
    bit ok;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e  = q.pop_front();
      gp = pg_of(e.id);
      ok = (gp === e.page) && (lk[e.id] === e.lk);
      if (e.bus) ok = ok && (oe[e.id] === e.oe) && (blk[e.id] === e.blk);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got page=%0d locked=%b oe_n=%b blk=%b, want page=%0d locked=%b oe_n=%b blk=%b (bus checked=%0d)",
                    e.name, gp, lk[e.id], oe[e.id], blk[e.id], e.page, e.lk, e.oe, e.blk, e.bus);
    end
  end

  task automatic expect_st(int due, int id, string nm, logic [5:0] pg, logic l);
    exp_t e;
    e.due = due; e.id = id; e.name = nm; e.page = pg; e.lk = l;
    e.bus = 1'b0; e.oe = 1'b1; e.blk = 1'b0;
    q.push_back(e);
  endtask

  task automatic expect_bus(int id, string nm, logic [5:0] pg, logic l, logic o, logic b);
    exp_t e;
    e.due = cyc; e.id = id; e.name = nm; e.page = pg; e.lk = l;
    e.bus = 1'b1; e.oe = o; e.blk = b;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic bus_idle();
    A13 = 1'b1; A14 = 1'b1; A15 = 1'b1; rd_n = 1'b1; mreq_n = 1'b1;
  endtask

  task automatic bus_lower_read(logic a13v);
    A13 = a13v; A14 = 1'b0; A15 = 1'b0; rd_n = 1'b0; mreq_n = 1'b0;
  endtask

  // One port cycle; the old page must still show 2 edges after the fall,
  // the new one after the 3rd edge.
  task automatic pulse(int id, string nm, logic a7v, logic wrv, logic [7:0] dv,
                       logic [5:0] old_pg, logic old_l, logic [5:0] new_pg, logic new_l);
    int f;
    step();
    A7 = a7v; wr_n = wrv; D = dv; iorq_n = 1'b0;
    f = cyc;
    expect_st(f + 2, id, {nm, "_pre"}, old_pg, old_l);
    expect_st(f + 3, id, nm, new_pg, new_l);
    repeat (3) step();
    iorq_n = 1'b1; A7 = 1'b1; wr_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #1;
    bus_lower_read(1'b0);
    expect_bus(0, "rom_visible_in_reset", 6'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    expect_bus(0, "boot_page0", 6'd0, 1'b0, 1'b0, 1'b1);
    step();
    A13 = 1'b1;
    expect_bus(0, "win8_a13_hi", 6'd0, 1'b0, 1'b1, 1'b0);
    expect_bus(1, "win16_a13_hi", 6'd0, 1'b0, 1'b0, 1'b1);
    step();
    bus_idle();

    pulse(0, "a7hi_1", 1'b1, 1'b1, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0);
    pulse(0, "a7hi_2", 1'b1, 1'b1, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0);
    pulse(0, "a7hi_3", 1'b1, 1'b1, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0);
    pulse(0, "inc_1",  1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 6'd1, 1'b0);
    pulse(0, "inc_2",  1'b0, 1'b1, 8'h00, 6'd1, 1'b0, 6'd2, 1'b0);
    pulse(0, "inc_3_lock", 1'b0, 1'b1, 8'h00, 6'd2, 1'b0, 6'd3, 1'b1);
    n_checks++;
    if (pg0 === 6'd3 && lk[0] === 1'b1) n_pass++;
    else $display("FAIL direct_lock: page=%0d locked=%b", pg0, lk[0]);
    bus_lower_read(1'b0);
    expect_bus(0, "locked_rom_hidden", 6'd3, 1'b1, 1'b1, 1'b0);
    step();
    bus_idle();
    pulse(0, "locked_frozen", 1'b0, 1'b1, 8'h00, 6'd3, 1'b1, 6'd3, 1'b1);
    n_checks++;
    if (pg0 === 6'd3) n_pass++;
    else $display("FAIL direct_frozen: page=%0d", pg0);

    do_reset();
    expect_st(cyc, 2, "load_after_reset", 6'd0, 1'b0);
    pulse(2, "wr_05",   1'b0, 1'b0, 8'h05, 6'd0, 1'b0, 6'd5, 1'b0);
    pulse(2, "rd_ignored", 1'b0, 1'b1, 8'h07, 6'd5, 1'b0, 6'd5, 1'b0);
    pulse(2, "wr_82_lock", 1'b0, 1'b0, 8'h82, 6'd5, 1'b0, 6'd2, 1'b1);
    n_checks++;
    if (pg2 === 6'd2 && lk[2] === 1'b1) n_pass++;
    else $display("FAIL direct_load_lock: page=%0d locked=%b", pg2, lk[2]);
    pulse(2, "wr_after_lock", 1'b0, 1'b0, 8'h09, 6'd2, 1'b1, 6'd2, 1'b1);

    do_reset();
    pulse(3, "wrap_1", 1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 6'd1, 1'b0);
    pulse(3, "wrap_2", 1'b0, 1'b1, 8'h00, 6'd1, 1'b0, 6'd2, 1'b0);
    pulse(3, "wrap_3", 1'b0, 1'b1, 8'h00, 6'd2, 1'b0, 6'd3, 1'b0);
    pulse(3, "wrap_0", 1'b0, 1'b1, 8'h00, 6'd3, 1'b0, 6'd0, 1'b0);
    pulse(3, "wrap_1b", 1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 6'd1, 1'b0);
    n_checks++;
    if (pg3 === 2'd1 && lk[3] === 1'b0) n_pass++;
    else $display("FAIL direct_wrap: page=%0d locked=%b", pg3, lk[3]);

    step();
    A7 = 1'b0; iorq_n = 1'b0;
    step();
    reset = 1'b1;
    expect_st(cyc, 3, "reset_mid_event", 6'd0, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    expect_st(cyc, 3, "release_iorq_low", 6'd0, 1'b0);
    iorq_n = 1'b1; A7 = 1'b1;
    repeat (5) step();
    expect_st(cyc, 3, "release_iorq_high", 6'd0, 1'b0);
    n_checks++;
    if (pg3 === 2'd0) n_pass++;
    else $display("FAIL direct_reset_abort: page=%0d", pg3);
    pulse(3, "first_after_reset", 1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 6'd1, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: expectation never sampled (due cycle %0d, now %0d)", e.name, e.due, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zx_cart_mapper.md
ZX_CART_MAPPER -- requirements
Module: zx_cart_mapper

Interface
REQ-001 Parameter PAGE_W, default 6: width of the cartridge ROM page register, legal range 1..7.
REQ-002 Parameter SELF_LOCK_VAL, default 63: page value that triggers self-lock; must be below 2^PAGE_W.
REQ-003 Parameter LOCK_EN, default 1: 1 enables self-lock, 0 lets the page counter wrap freely.
REQ-004 Parameter MODE, default 0: 0 selects INC (page advances on each port access); 1 selects LOAD (page written from the data bus).
REQ-005 Parameter WIN_KB, default 8: size of the lower cartridge window, 8 or 16.
REQ-006 clk  in  1  system clock, at least 4x the Z80 clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 iorq_n, rd_n, wr_n, mreq_n  in  1 each  Z80 bus strobes, asynchronous to clk.
REQ-009 A7, A13, A14, A15  in  1 each  Z80 address bits.
REQ-010 D  in  8  Z80 data bus; used only when MODE=1.
REQ-011 ZX_ROM_blk  out  1  high blocks the host ZX ROM.
REQ-012 CR_ROM_oe_n  out  1  active-low output enable of the cartridge ROM.
REQ-013 CR_ROM_A  out  PAGE_W  cartridge ROM page (upper address bits).
REQ-014 locked  out  1  high while the FSM is in LOCKED.

Function
REQ-015 lower_rom shall be high when A15=A14=A13=0 (WIN_KB=8), or when A15=A14=0 with A13 ignored (WIN_KB=16).
REQ-016 CR_ROM_oe_n shall equal NOT(lower_rom AND NOT rd_n AND NOT mreq_n AND NOT locked), decoded combinationally with no clk latency.
REQ-017 ZX_ROM_blk shall equal lower_rom AND NOT mreq_n AND NOT locked, decoded combinationally.
REQ-018 iorq_n shall pass through a 2-flop synchroniser; A7, wr_n and D[7:0] shall pass through a matching 2-stage delay so that they stay aligned with it.
REQ-019 A port event is a 1->0 transition of synchronised iorq_n with synchronised A7=0, and produces exactly one clk cycle of event pulse per falling edge.
REQ-020 In MODE=0, each port event shall increment CR_ROM_A by 1 modulo 2^PAGE_W.
REQ-021 In MODE=1, a port event with synchronised wr_n=0 shall load CR_ROM_A from D[PAGE_W-1:0]; D[7]=1 in the same write requests lock; events with wr_n=1 are ignored.
REQ-022 Latency: a new CR_ROM_A value and the matching locked value shall appear after the 3rd rising clk edge following the iorq_n fall.
REQ-023 FSM states: ACTIVE and LOCKED; reset enters ACTIVE.
REQ-024 ACTIVE -> LOCKED when LOCK_EN=1 and the updated page equals SELF_LOCK_VAL, or on a MODE=1 lock request; the transition occurs in the same cycle as the page update.
REQ-025 LOCKED is terminal until reset: port events are ignored and CR_ROM_A is frozen at its lock value.
REQ-026 With LOCK_EN=0, the counter wraps from 2^PAGE_W-1 to 0 and locked stays 0.
REQ-027 Back-to-back iorq_n pulses spaced at least 3 clk apart shall each produce exactly one update; glitches shorter than 1 clk need not register.

Reset
REQ-028 reset high shall force CR_ROM_A=0, locked=0, FSM=ACTIVE, and all synchroniser and edge-detect flops to the idle value 1 (A7 and D flops to 0), asynchronously.
REQ-029 The cartridge ROM shall be visible during and immediately after reset, so that the Z80 boots from page 0.
REQ-030 Asserting reset mid-sequence shall abort any pending event; no increment shall occur on release even if iorq_n is low at that moment.

Structure
REQ-031 Package zx_cart_pkg shall hold the FSM state type (ACTIVE, LOCKED) and the MODE constants MODE_INC=0 and MODE_LOAD=1.
REQ-032 Sub-module zx_sync_edge (2-flop synchroniser plus falling-edge pulse, reset to 1) shall be instantiated for iorq_n.

Verification
REQ-033 MODE=0, PAGE_W=6, SELF_LOCK_VAL=3: three iorq_n pulses with A7=1 -> CR_ROM_A stays 0; three pulses with A7=0 -> CR_ROM_A goes 1, 2, 3, then locked=1.
REQ-034 With locked=1, drive A15..A13=0, rd_n=0, mreq_n=0 -> CR_ROM_oe_n=1 and ZX_ROM_blk=0; a further port event leaves CR_ROM_A=3.
REQ-035 After reset, with lower_rom and rd_n=mreq_n=0 -> CR_ROM_oe_n=0 and ZX_ROM_blk=1; setting A13=1 (WIN_KB=8) -> CR_ROM_oe_n=1; with WIN_KB=16, A13=1 keeps CR_ROM_oe_n=0.
REQ-036 MODE=1: write D=0x05 -> CR_ROM_A=5 exactly 3 clk after the iorq_n fall with locked=0; write D=0x82 -> CR_ROM_A=2 and locked=1; a read event changes nothing.
REQ-037 LOCK_EN=0, PAGE_W=2: five port events -> CR_ROM_A sequence 1, 2, 3, 0, 1 with locked=0; assert reset while iorq_n is low -> CR_ROM_A=0 and no increment after release.
